// File: rtl/queue_pkg.sv
// Shared constants and helpers for the one-hot queue controller.
// Optional almost-full/almost-empty flags are enabled by QUEUE_ALMOST_FLAGS_EN.
package queue_pkg;

  localparam int QUEUE_ADDR_W = 10;
  localparam int QUEUE_DATA_W = 8;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Enable-gated one-hot decoder used for the queue's write-word select.
// Replaces the fixed-width decoder tree with a single parametrised stage.
module onehot_dec #(
  parameter int IN_W = 4
)(
  input  logic [IN_W-1:0]       in,
  input  logic                  en,
  output logic [(1<<IN_W)-1:0]  out
);

  localparam int OUT_W = 1 << IN_W;

  always_comb begin
    out = '0;
    if (en) out = OUT_W'(1) << in;
  end

endmodule

// File: rtl/onehot_queue_ctrl.sv
// RAM-backed queue with one-hot write select, occupancy tracking and sticky errors.
// Define QUEUE_ALMOST_FLAGS_EN to add the AF_LVL/AE_LVL almost-full/empty outputs.
module onehot_queue_ctrl
  import queue_pkg::*;
#(
  parameter int ADDR_W = QUEUE_ADDR_W,
  parameter int DATA_W = QUEUE_DATA_W
`ifdef QUEUE_ALMOST_FLAGS_EN
  ,
  parameter int AF_LVL = depth_of(ADDR_W) - 4,
  parameter int AE_LVL = 4
`endif
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            din,
  input  logic                         pop,
  output logic [DATA_W-1:0]            dout,
  output logic                         dout_valid,
  output logic                         full,
  output logic                         empty,
  output logic [ADDR_W:0]              count,
  output logic [depth_of(ADDR_W)-1:0]  wr_sel,
  output logic                         overflow,
  output logic                         underflow
`ifdef QUEUE_ALMOST_FLAGS_EN
  ,
  output logic                         almost_full,
  output logic                         almost_empty
`endif
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_dout;
  logic              r_doutValid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_pushOk;
  logic              w_popOk;
  logic [ADDR_W:0]   w_countNext;
  logic [DEPTH-1:0]  w_wrSel;

  // A push at full is still accepted when a pop frees the head slot this cycle.
  assign w_pushOk = push & (~r_full | pop);
  assign w_popOk  = pop & ~r_empty;

  onehot_dec #(
    .IN_W (ADDR_W)
  ) u_wrDec (
    .in  (r_wrPtr),
    .en  (w_pushOk),
    .out (w_wrSel)
  );

  always_comb begin
    w_countNext = r_count;
    if (w_pushOk && !w_popOk)
      w_countNext = r_count + (ADDR_W+1)'(1);
    else if (w_popOk && !w_pushOk)
      w_countNext = r_count - (ADDR_W+1)'(1);
  end

  // Storage is deliberately left unreset; stale words never reach dout.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wrSel[i]) r_mem[i] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_dout      <= '0;
      r_doutValid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + ADDR_W'(1);
      if (w_popOk) begin
        r_rdPtr <= r_rdPtr + ADDR_W'(1);
        r_dout  <= r_mem[r_rdPtr];
      end
      r_doutValid <= w_popOk;
      r_count     <= w_countNext;
      r_full      <= (w_countNext == DEPTH_C);
      r_empty     <= (w_countNext == '0);
      if (push && r_full && !pop) r_overflow <= 1'b1;
      if (pop && r_empty) r_underflow <= 1'b1;
    end
  end

`ifdef QUEUE_ALMOST_FLAGS_EN
  localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LVL);

  logic r_almostFull;
  logic r_almostEmpty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_almostFull  <= 1'b0;
      r_almostEmpty <= 1'b1;
    end else begin
      r_almostFull  <= (w_countNext >= AF_C);
      r_almostEmpty <= (w_countNext <= AE_C);
    end
  end

  assign almost_full  = r_almostFull;
  assign almost_empty = r_almostEmpty;
`endif

  assign dout       = r_dout;
  assign dout_valid = r_doutValid;
  assign full       = r_full;
  assign empty      = r_empty;
  assign count      = r_count;
  assign wr_sel     = w_wrSel;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_onehot_queue_ctrl.sv
// Directed self-checking bench for onehot_queue_ctrl at ADDR_W=4, DATA_W=8.
// Almost-flag checks are compiled in when QUEUE_ALMOST_FLAGS_EN is defined.
module tb_onehot_queue_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              push;
  logic [DATA_W-1:0] din;
  logic              pop;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic [DEPTH-1:0]  wr_sel;
  logic              overflow;
  logic              underflow;
`ifdef QUEUE_ALMOST_FLAGS_EN
  logic              almost_full;
  logic              almost_empty;
`endif

  int total = 0;
  int bad   = 0;

  onehot_queue_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .din        (din),
    .pop        (pop),
    .dout       (dout),
    .dout_valid (dout_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .wr_sel     (wr_sel),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef QUEUE_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given request pattern; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic p, input logic [DATA_W-1:0] d, input logic q);
    push = p;
    din  = d;
    pop  = q;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    din  = '0;
    #1;
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_dvalid", 32'(dout_valid), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_unf", 32'(underflow), 32'd0);
`ifdef QUEUE_ALMOST_FLAGS_EN
    checkOutput("rst_af", 32'(almost_full), 32'd0);
    checkOutput("rst_ae", 32'(almost_empty), 32'd1);
`endif

    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pop_empty_unf", 32'(underflow), 32'd1);
    checkOutput("pop_empty_dvalid", 32'(dout_valid), 32'd0);
    checkOutput("pop_empty_count", 32'(count), 32'd0);

    $display("[TB] fill and overflow");
    for (int i = 0; i < DEPTH; i++) begin
      push = 1'b1;
      din  = 8'(i);
      pop  = 1'b0;
      #1;
      checkOutput($sformatf("fill_wrsel_%0d", i), 32'(wr_sel), 32'(1) << i);
      applyStimulus(1'b1, 8'(i), 1'b0);
      checkOutput($sformatf("fill_count_%0d", i), 32'(count), 32'(i + 1));
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_empty", 32'(empty), 32'd0);
    push = 1'b1;
    din  = 8'hAA;
    #1;
    checkOutput("ovf_wrsel", 32'(wr_sel), 32'd0);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_count", 32'(count), 32'd16);
    checkOutput("ovf_full", 32'(full), 32'd1);

    $display("[TB] drain order");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("drain_dout_%0d", i), 32'(dout), 32'(i));
      checkOutput($sformatf("drain_dvalid_%0d", i), 32'(dout_valid), 32'd1);
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_count", 32'(count), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("idle_dvalid", 32'(dout_valid), 32'd0);
    checkOutput("idle_dout_hold", 32'(dout), 32'h0F);

    $display("[TB] pointer wrap");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
    checkOutput("wrap_count10", 32'(count), 32'd10);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("wrap_a_%0d", i), 32'(dout), 32'(8'h20 + i));
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("wrap_b_%0d", i), 32'(dout), 32'(8'h30 + i));
    end
    checkOutput("wrap_count0", 32'(count), 32'd0);
    checkOutput("wrap_empty", 32'(empty), 32'd1);

    $display("[TB] simultaneous push/pop at full");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    checkOutput("sim_full_pre", 32'(full), 32'd1);
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("sim_full_dout", 32'(dout), 32'h40);
    checkOutput("sim_full_dvalid", 32'(dout_valid), 32'd1);
    checkOutput("sim_full_count", 32'(count), 32'd16);
    checkOutput("sim_full_full", 32'(full), 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("sim_full_drain_%0d", i), 32'(dout), 32'(8'h40 + i));
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("sim_full_newword", 32'(dout), 32'h55);
    checkOutput("sim_full_empty", 32'(empty), 32'd1);

    $display("[TB] simultaneous push/pop at empty");
    doReset();
    checkOutput("rst2_ovf", 32'(overflow), 32'd0);
    checkOutput("rst2_unf", 32'(underflow), 32'd0);
    applyStimulus(1'b1, 8'h66, 1'b1);
    checkOutput("sim_empty_count", 32'(count), 32'd1);
    checkOutput("sim_empty_unf", 32'(underflow), 32'd1);
    checkOutput("sim_empty_dvalid", 32'(dout_valid), 32'd0);
    checkOutput("sim_empty_empty", 32'(empty), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("sim_empty_dout", 32'(dout), 32'h66);
    checkOutput("sim_empty_dvalid2", 32'(dout_valid), 32'd1);
    checkOutput("sim_empty_count0", 32'(count), 32'd0);

    $display("[TB] mid-operation reset");
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0);
    checkOutput("mid_count13", 32'(count), 32'd13);
`ifdef QUEUE_ALMOST_FLAGS_EN
    checkOutput("mid_af", 32'(almost_full), 32'd1);
    checkOutput("mid_ae", 32'(almost_empty), 32'd0);
`endif
    rst = 1'b1;
    applyStimulus(1'b1, 8'hEE, 1'b1);
    rst = 1'b0;
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_empty", 32'(empty), 32'd1);
    checkOutput("mid_rst_dout", 32'(dout), 32'd0);
    checkOutput("mid_rst_unf", 32'(underflow), 32'd0);
    checkOutput("mid_rst_ovf", 32'(overflow), 32'd0);
`ifdef QUEUE_ALMOST_FLAGS_EN
    checkOutput("mid_rst_af", 32'(almost_full), 32'd0);
    checkOutput("mid_rst_ae", 32'(almost_empty), 32'd1);
`endif
    applyStimulus(1'b1, 8'h99, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("mid_roundtrip", 32'(dout), 32'h99);
    checkOutput("mid_roundtrip_dv", 32'(dout_valid), 32'd1);
    checkOutput("mid_final_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
